sauce_vend_ctrl: RTL and testbench

//  Downstream stage of the sauce datapath in the Flag Vending Machine.
//  - Debounces BTNL.
//  - Captures the 8-bit sauce byte (the Disp output of the sauce stage) on each debounced press.
//  - After CODE_LEN captures, compares the collected sequence against a fixed code.
//  - On a match, streams a flag ROM out over a valid/ready byte interface.
//  - Repeated mismatches trigger a timed lockout.

---
 rtl/sauce_pkg.sv | 28 ++
 rtl/btn_debounce.sv | 45 ++++
 rtl/sauce_vend_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sauce_vend_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sauce_pkg.sv
// Shared types and constants for the sauce vending controller: FSM encoding,
// the unlock code and the flag ROM contents.
package sauce_pkg;

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_CHECK   = 3'd1,
        ST_VEND    = 3'd2,
        ST_DONE    = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    // Code bytes are left-aligned: byte 0 of an attempt sits in bits [63:56].
    localparam logic [63:0] CODE = 64'h1F2E3D4C_00000000;

    localparam int FLAG_LEN = 16;

    // "FLAG{s4uce_c0d3}"
    localparam logic [7:0] FLAG_ROM [FLAG_LEN] = '{
        8'h46, 8'h4C, 8'h41, 8'h47, 8'h7B, 8'h73, 8'h34, 8'h75,
        8'h63, 8'h65, 8'h5F, 8'h63, 8'h30, 8'h64, 8'h33, 8'h7D
    };

    function automatic logic [7:0] code_byte(input int idx);
        return CODE[63 - 8*idx -: 8];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stable-level debounce counter
// and a single-cycle pulse on each debounced rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          btn_meta;
    logic          btn_sync;
    logic          btn_db_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            cnt      <= '0;
        end else begin
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
            btn_db_q <= btn_db;
            // Any return to the accepted level restarts the stability window.
            if (btn_sync == btn_db) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                btn_db <= btn_sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = btn_db & ~btn_db_q;

endmodule

// File: rtl/sauce_vend_ctrl.sv
// Collects CODE_LEN debounced sauce bytes, checks them against the fixed code,
// streams the flag ROM on a match and locks out after repeated mismatches.
module sauce_vend_ctrl
    import sauce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CODE_LEN        = 4,
    parameter int MAX_FAILS       = 3,
    parameter int LOCKOUT_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BTNL,
    input  logic [7:0] sauce_in,
    input  logic       flag_ready,
    output logic       flag_valid,
    output logic [7:0] flag_byte,
    output logic       unlocked,
    output logic       locked_out,
    output logic [3:0] entry_count,
    output state_t     state_dbg
);

    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam int PW = $clog2(FLAG_LEN);

    state_t        state;
    state_t        state_nxt;
    logic          btn_db;
    logic          press;
    logic          capture;
    logic          code_match;
    logic          fail_last;
    logic [7:0]    sauce_meta;
    logic [7:0]    sauce_sync;
    logic [7:0]    code_buf [8];
    logic [FW-1:0] fail_cnt;
    logic [TW-1:0] lock_timer;
    logic [PW-1:0] ptr;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(BTNL),
        .btn_db (btn_db),
        .press  (press)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sauce_meta <= '0;
            sauce_sync <= '0;
        end else begin
            sauce_meta <= sauce_in;
            sauce_sync <= sauce_meta;
        end
    end

    always_comb begin
        code_match = 1'b1;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (code_buf[i] != code_byte(i)) code_match = 1'b0;
        end
    end

    assign fail_last = (fail_cnt + 1'b1) == FW'(MAX_FAILS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_COLLECT;
        else      state <= state_nxt;
    end

    // Flag stream handshake: a byte transfers on every cycle where flag_valid
    // and flag_ready are both high; flag_valid never depends on flag_ready and
    // flag_byte stays fixed until the transfer happens.
    always_comb begin
        state_nxt  = state;
        capture    = 1'b0;
        flag_valid = 1'b0;
        flag_byte  = 8'h00;
        locked_out = 1'b0;
        case (state)
            ST_COLLECT: begin
                if (press && btn_db && (entry_count < 4'(CODE_LEN))) begin
                    capture = 1'b1;
                    if (entry_count == 4'(CODE_LEN - 1)) state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (code_match)     state_nxt = ST_VEND;
                else if (fail_last) state_nxt = ST_LOCKOUT;
                else                state_nxt = ST_COLLECT;
            end
            ST_VEND: begin
                flag_valid = 1'b1;
                flag_byte  = FLAG_ROM[ptr];
                if (flag_ready && (ptr == PW'(FLAG_LEN - 1))) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            ST_LOCKOUT: begin
                locked_out = 1'b1;
                if (lock_timer == '0) state_nxt = ST_COLLECT;
            end
            default: begin
                state_nxt = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) code_buf[i] <= '0;
            entry_count <= '0;
            fail_cnt    <= '0;
            lock_timer  <= '0;
            ptr         <= '0;
            unlocked    <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (capture) begin
                        code_buf[entry_count[2:0]] <= sauce_sync;
                        entry_count                <= entry_count + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (code_match) begin
                        unlocked <= 1'b1;
                        fail_cnt <= '0;
                    end else begin
                        fail_cnt    <= fail_cnt + 1'b1;
                        entry_count <= '0;
                        if (fail_last) lock_timer <= TW'(LOCKOUT_CYCLES - 1);
                    end
                end
                ST_VEND: begin
                    if (flag_ready) ptr <= ptr + 1'b1;
                end
                ST_LOCKOUT: begin
                    if (lock_timer == '0) begin
                        fail_cnt    <= '0;
                        entry_count <= '0;
                    end else begin
                        lock_timer <= lock_timer - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_sauce_vend_ctrl.sv
// Directed bench for sauce_vend_ctrl: unlock, backpressure, lockout, async
// reset mid-stream and long button hold, with a flag-byte scoreboard.
module tb_sauce_vend_ctrl;
    import sauce_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       BTNL = 1'b0;
    logic [7:0] sauce_in = 8'h00;
    logic       flag_ready = 1'b0;
    logic       flag_valid;
    logic [7:0] flag_byte;
    logic       unlocked;
    logic       locked_out;
    logic [3:0] entry_count;
    state_t     state_dbg;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    logic       stalled = 1'b0;
    logic [7:0] held_byte = 8'h00;
    string      flag_str = "FLAG{s4uce_c0d3}";
    logic [7:0] good_code [4] = '{8'h1F, 8'h2E, 8'h3D, 8'h4C};

    sauce_vend_ctrl #(
        .DEBOUNCE_CYCLES(8),
        .CODE_LEN       (4),
        .MAX_FAILS      (3),
        .LOCKOUT_CYCLES (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .BTNL       (BTNL),
        .sauce_in   (sauce_in),
        .flag_ready (flag_ready),
        .flag_valid (flag_valid),
        .flag_byte  (flag_byte),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .entry_count(entry_count),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise BTNL and wait (bounded) for entry_count to move; BTNL is left high.
    task automatic press_byte(input logic [7:0] b, output bit got);
        logic [3:0] old;
        sauce_in = b;
        cycles(3);
        BTNL = 1'b1;
        old = entry_count;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (entry_count != old) got = 1'b1;
        end
    endtask

    task automatic release_btn();
        BTNL = 1'b0;
        cycles(14);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, flag_valid, 0);
        chk({tag, "_byte"}, flag_byte, 0);
        chk({tag, "_unlocked"}, unlocked, 0);
        chk({tag, "_locked"}, locked_out, 0);
        chk({tag, "_entry"}, entry_count, 0);
        chk({tag, "_state"}, state_dbg, ST_COLLECT);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        cycles(2);
        chk_reset_outputs("rst");
        rst = 1'b1;
        cycles(2);
    endtask

    task automatic enter_good_code(input bit push_flag);
        bit got;
        for (int k = 0; k < 4; k++) begin
            press_byte(good_code[k], got);
            chk("good_cap", got, 1);
            chk("good_entry", entry_count, k + 1);
            if (k == 3) begin
                chk("check_state", state_dbg, ST_CHECK);
                if (push_flag)
                    for (int j = 0; j < FLAG_LEN; j++) exp_q.push_back(flag_str[j]);
                @(negedge clk);
                chk("unlock_next", unlocked, 1);
                chk("valid_next", flag_valid, 1);
                chk("first_byte", flag_byte, flag_str[0]);
            end
            release_btn();
        end
    endtask

    // Scoreboard side: pops an expected byte on each transfer and checks that a
    // stalled byte does not change before it is accepted.
    always @(negedge clk) begin
        if (rst && flag_valid) begin
            if (stalled) chk("hold", flag_byte, held_byte);
            if (flag_ready) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL extra_byte: got %0h expected none", flag_byte);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("flag_byte", flag_byte, exp_b);
                end
                stalled <= 1'b0;
            end else begin
                stalled   <= 1'b1;
                held_byte <= flag_byte;
            end
        end else begin
            stalled <= 1'b0;
        end
    end

    initial begin
        bit got;
        int lock_len;
        bit lock_entry_bad;

        cycles(3);
        chk_reset_outputs("init");
        rst = 1'b1;
        cycles(2);

        // Short glitch must not register as a press.
        BTNL = 1'b1;
        cycles(5);
        BTNL = 1'b0;
        cycles(20);
        chk("glitch_entry", entry_count, 0);

        // Correct code unlocks and presents byte 0.
        enter_good_code(1'b1);

        // Accept bytes 0..2, stall on byte 3 for 5 cycles, then drain.
        flag_ready = 1'b1;
        cycles(3);
        flag_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_byte", flag_byte, flag_str[3]);
        end
        @(posedge clk);
        #1 flag_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycles(1);
        chk("drained", exp_q.size(), 0);
        @(negedge clk);
        chk("done_valid", flag_valid, 0);
        chk("done_state", state_dbg, ST_DONE);
        chk("done_unlocked", unlocked, 1);
        flag_ready = 1'b0;
        cycles(2);

        // Three wrong attempts lead to a 32-cycle lockout.
        do_reset();
        for (int a = 0; a < 3; a++) begin
            for (int k = 0; k < 4; k++) begin
                press_byte(8'h00, got);
                chk("bad_cap", got, 1);
                if (a == 2 && k == 3) break;
                release_btn();
            end
            if (a < 2) begin
                chk("bad_entry_clr", entry_count, 0);
                chk("bad_state", state_dbg, ST_COLLECT);
            end
        end
        chk("bad_check_state", state_dbg, ST_CHECK);
        lock_len = 0;
        lock_entry_bad = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (locked_out) lock_len++;
            else if (lock_len > 0) break;
            if (entry_count != 4'd0) lock_entry_bad = 1'b1;
            if (i == 0) BTNL = 1'b0;
            if (i == 14) BTNL = 1'b1;
            if (i == 28) BTNL = 1'b0;
        end
        chk("lock_len", lock_len, 32);
        chk("lock_entry", lock_entry_bad, 0);
        cycles(14);
        chk("post_lock_entry", entry_count, 0);
        chk("post_lock_state", state_dbg, ST_COLLECT);
        enter_good_code(1'b0);

        // Stream bytes 0..6, stall at ptr=7, then reset without a clock edge.
        for (int j = 0; j < 7; j++) exp_q.push_back(flag_str[j]);
        @(posedge clk);
        #1 flag_ready = 1'b1;
        cycles(7);
        flag_ready = 1'b0;
        @(negedge clk);
        chk("ptr7_byte", flag_byte, flag_str[7]);
        #2 rst = 1'b0;
        #1;
        chk_reset_outputs("async");
        cycles(2);
        rst = 1'b1;
        cycles(3);
        chk("after_rst_state", state_dbg, ST_COLLECT);
        chk("after_rst_q", exp_q.size(), 0);

        // A long hold is a single capture.
        sauce_in = 8'hAA;
        cycles(3);
        BTNL = 1'b1;
        cycles(200);
        chk("hold_entry", entry_count, 1);
        release_btn();
        cycles(6);
        chk("hold_entry_rel", entry_count, 1);

        chk("final_q", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
